hex_scan_controller: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment bank that shares one hex_display decoder. Holds a double-buffered hex word, steps through the digits one at a time, and presents each nibble plus a blanking flag to the shared decoder. It drives active-low digit enables and inserts an all-off guard gap between digits to prevent ghosting. New words are committed only at frame boundaries, so the display never shows a partial update.

---
 rtl/hex_scan_controller.sv | 153 +++++++++++++++
 tb/tb_hex_scan_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank sharing one decoder.
// Double-buffered hex word, committed only at frame boundaries; guard gap between digits.
module hex_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    blank_zeros,
  output logic [3:0]              digit_value,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nx;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic                    r_pend_valid;
  logic                    r_load_ack;
  logic                    r_frame_done;
  logic                    r_bz;
  logic                    w_want;
  logic                    w_commit;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_upper_zero;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_commit   = 1'b0;
    w_wrap     = 1'b0;
    w_want     = r_pend_valid | load;
    case (r_state)
      S_IDLE: begin
        if (w_want) begin
          w_state_nx = S_ON;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
          w_commit   = 1'b1;
        end
      end
      S_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nx = S_GUARD;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nx = S_ON;
          w_cnt_nx   = '0;
          // Last digit's guard ends the frame: the only point a new word may land.
          if (r_idx == IDX_LAST) begin
            w_idx_nx = '0;
            w_wrap   = 1'b1;
            w_commit = w_want;
          end else begin
            w_idx_nx = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      r_bz         <= 1'b0;
    end else begin
      r_load_ack   <= w_commit;
      r_frame_done <= w_wrap;
      r_bz         <= blank_zeros;
      if (load) begin
        r_pending <= data;
      end
      // A write on the commit edge bypasses the buffer so it is never lost.
      if (w_commit) begin
        r_active     <= load ? data : r_pending;
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nib        = 4'h0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib = r_active[4*i +: 4];
      end
      if ((IDX_W'(i) >= r_idx) && (r_active[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign digit_sel   = (r_state == S_ON) ? ~(NUM_DIGITS'(1) << r_idx) : '1;
  assign digit_value = (r_state == S_IDLE) ? 4'h0 : w_nib;
  assign blank       = (r_state != S_ON) ? 1'b1
                     : (r_bz && (r_idx != '0) && w_upper_zero);
  assign load_ack    = r_load_ack;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Bench for hex_scan_controller: per-cycle vector table feeding an expected-output scoreboard,
// plus hand-written reset sequences. Frame is 20 cycles (4 digits x (4 on + 1 guard)).
module tb_hex_scan_controller;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          load;
  logic [15:0]   data;
  logic          blank_zeros;
  logic [3:0]    digit_value;
  logic          blank;
  logic [ND-1:0] digit_sel;
  logic          load_ack;
  logic          frame_done;

  hex_scan_controller #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .data       (data),
    .blank_zeros(blank_zeros),
    .digit_value(digit_value),
    .blank      (blank),
    .digit_sel  (digit_sel),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] d;
    logic        bz;
    logic [3:0]  sel;
    logic [3:0]  val;
    logic        blank;
    logic        ack;
    logic        fd;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] val;
    logic       blank;
    logic       ack;
    logic       fd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_idle(input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.ld = 1'b0; v.d = 16'h0; v.bz = 1'b0;
      v.sel = 4'b1111; v.val = 4'h0; v.blank = 1'b1; v.ack = 1'b0; v.fd = 1'b0;
      vecs.push_back(v);
    end
  endtask

  // Expected outputs for (the first n cycles of) one frame displaying word w.
  task automatic add_frame(input logic [15:0] w, input bit bz, input bit ack, input bit fd,
                           input int n);
    vec_t v;
    int   dg;
    bit   on;
    for (int k = 0; k < n; k++) begin
      dg      = k / 5;
      on      = (k % 5) < 4;
      v.ld    = 1'b0;
      v.d     = 16'h0;
      v.bz    = bz;
      v.sel   = on ? ~(4'b0001 << dg) : 4'b1111;
      v.val   = w[4*dg +: 4];
      v.blank = on ? (bz && (dg != 0) && ((w >> (4*dg)) == 16'h0)) : 1'b1;
      v.ack   = (k == 0) && ack;
      v.fd    = (k == 0) && fd;
      vecs.push_back(v);
    end
  endtask

  task automatic set_load(input int i, input logic [15:0] d);
    vec_t t;
    t = vecs[i];
    t.ld = 1'b1;
    t.d  = d;
    vecs[i] = t;
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("cyc%0d digit_sel", cyc), 32'(digit_sel), 32'(e.sel));
      chk($sformatf("cyc%0d digit_value", cyc), 32'(digit_value), 32'(e.val));
      chk($sformatf("cyc%0d blank", cyc), 32'(blank), 32'(e.blank));
      chk($sformatf("cyc%0d load_ack", cyc), 32'(load_ack), 32'(e.ack));
      chk($sformatf("cyc%0d frame_done", cyc), 32'(frame_done), 32'(e.fd));
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    load        = v.ld;
    data        = v.d;
    blank_zeros = v.bz;
    e.sel = v.sel; e.val = v.val; e.blank = v.blank; e.ack = v.ack; e.fd = v.fd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_sb();
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " digit_sel"}, 32'(digit_sel), 32'hF);
    chk({tag, " digit_value"}, 32'(digit_value), 32'h0);
    chk({tag, " blank"}, 32'(blank), 32'h1);
    chk({tag, " load_ack"}, 32'(load_ack), 32'h0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  int base;
  int start;

  initial begin
    n_rst       = 1'b0;
    load        = 1'b0;
    data        = 16'h0;
    blank_zeros = 1'b0;
    #12;
    check_reset_outputs("in_reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Idle 50 cycles, then the scan sequence across several frames.
    add_idle(50);
    base = vecs.size(); add_frame(16'h1A2F, 0, 1, 0, 20); set_load(base, 16'h1A2F);
    base = vecs.size(); add_frame(16'h1A2F, 0, 0, 1, 20);
    set_load(base + 5, 16'h1111); set_load(base + 6, 16'h2222);
    base = vecs.size(); add_frame(16'h2222, 0, 1, 1, 20); set_load(base + 10, 16'h0070);
    base = vecs.size(); add_frame(16'h0070, 1, 1, 1, 20); set_load(base + 3, 16'h0000);
    base = vecs.size(); add_frame(16'h0000, 1, 1, 1, 20); set_load(base + 8, 16'h1234);
    base = vecs.size(); add_frame(16'hBEEF, 0, 1, 1, 20); set_load(base, 16'hBEEF);
    add_frame(16'hBEEF, 0, 0, 1, 20);
    add_frame(16'hBEEF, 0, 0, 1, 11);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    chk("pre_reset digit_sel_d2", 32'(digit_sel), 32'hB);
    chk("pre_reset digit_value_d2", 32'(digit_value), 32'hE);

    // Asynchronous reset while digit 2 is lit.
    #3;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    check_reset_outputs("held_reset");
    n_rst = 1'b1;

    start = vecs.size();
    add_idle(3);
    base = vecs.size(); add_frame(16'h5678, 0, 1, 0, 6); set_load(base, 16'h5678);
    for (int i = start; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
